// File: rtl/tb_virt_periph_pkg.sv
// Shared register map and helpers for the testbench virtual peripheral.
package tb_virt_periph_pkg;

  localparam logic [7:0] OFS_STDOUT      = 8'h00;
  localparam logic [7:0] OFS_TEST_STATUS = 8'h04;
  localparam logic [7:0] OFS_EXIT        = 8'h08;
  localparam logic [7:0] OFS_CYCLE       = 8'h10;
  localparam logic [7:0] OFS_TIMER_CMP   = 8'h14;
  localparam logic [7:0] OFS_TIMER_CTRL  = 8'h18;

  localparam logic [31:0] DEFAULT_RDATA = 32'hDEAD_BEEF;

  typedef enum int unsigned {
    TCTRL_EN   = 0,
    TCTRL_PEND = 1
  } timer_ctrl_bit_e;

  // Byte-lane merge of a write into an existing register value.
  function automatic logic [31:0] apply_be(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      r[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/tb_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a pop in the same cycle frees a slot for a push.
module tb_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             core_clk,
  input  logic             core_rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: it is only observed through non-empty pointers.
  always_ff @(posedge core_clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/tb_virt_periph.sv
// OBI-attached virtual peripheral: stdout FIFO, test status/exit, cycle counter, compare timer.
module tb_virt_periph
  import tb_virt_periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h2000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] PASS_MAGIC = 32'd123456789
) (
  input  logic        core_clk,
  input  logic        core_rst_n,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        sel_o,
  output logic        stdout_valid_o,
  input  logic        stdout_ready_i,
  output logic [7:0]  stdout_char_o,
  output logic        tests_passed_o,
  output logic        tests_failed_o,
  output logic        exit_valid_o,
  output logic [31:0] exit_value_o,
  output logic        irq_timer_o
);
  logic [7:0]  ofs;
  logic        is_stdout, wr, rd, fifo_full, fifo_empty, fifo_pop, full_eff;
  logic [7:0]  fifo_data;
  logic [31:0] rd_mux;

  logic        rvalid_q, pass_q, pass_d, fail_q, fail_d, exit_vld_q, exit_vld_d;
  logic [31:0] rdata_q, rdata_d, exit_val_q, exit_val_d;
  logic [31:0] cycle_q, cycle_d, cmp_q, cmp_d;
  logic        en_q, en_d, pend_q, pend_d, tmr_set;

  assign ofs       = addr_i[7:0];
  assign sel_o     = req_i & (addr_i[31:8] == BASE_ADDR[31:8]);
  assign is_stdout = (ofs == OFS_STDOUT);
  assign fifo_pop  = ~fifo_empty & stdout_ready_i;
  // A pop this cycle frees a slot, so a full FIFO can still accept the push.
  assign full_eff  = fifo_full & ~fifo_pop;
  assign gnt_o     = sel_o & ~(we_i & is_stdout & full_eff);
  assign wr        = gnt_o & we_i;
  assign rd        = gnt_o & ~we_i;

  tb_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_stdout_fifo (
    .core_clk   (core_clk),
    .core_rst_n (core_rst_n),
    .push_i     (wr & is_stdout),
    .data_i     (wdata_i[7:0]),
    .pop_i      (fifo_pop),
    .data_o     (fifo_data),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign stdout_valid_o = ~fifo_empty;
  assign stdout_char_o  = fifo_empty ? 8'h00 : fifo_data;

  always_comb begin
    rd_mux = DEFAULT_RDATA;
    case (ofs)
      OFS_STDOUT, OFS_TEST_STATUS, OFS_EXIT: rd_mux = '0;
      OFS_CYCLE:      rd_mux = cycle_q;
      OFS_TIMER_CMP:  rd_mux = cmp_q;
      OFS_TIMER_CTRL: begin
        rd_mux             = '0;
        rd_mux[TCTRL_EN]   = en_q;
        rd_mux[TCTRL_PEND] = pend_q;
      end
      default: rd_mux = DEFAULT_RDATA;
    endcase
  end

  assign tmr_set = en_q & (cycle_q == cmp_q);

  always_comb begin
    rdata_d    = rd ? rd_mux : '0;
    pass_d     = wr & (ofs == OFS_TEST_STATUS) & (wdata_i == PASS_MAGIC);
    fail_d     = wr & (ofs == OFS_TEST_STATUS) & (wdata_i == 32'd1);
    exit_vld_d = wr & (ofs == OFS_EXIT);
    exit_val_d = exit_vld_d ? wdata_i : exit_val_q;
    cycle_d    = (wr && ofs == OFS_CYCLE) ? apply_be(cycle_q, wdata_i, be_i) : cycle_q + 32'd1;
    cmp_d      = (wr && ofs == OFS_TIMER_CMP) ? apply_be(cmp_q, wdata_i, be_i) : cmp_q;
    en_d       = (wr && ofs == OFS_TIMER_CTRL) ? wdata_i[TCTRL_EN] : en_q;
    pend_d     = pend_q;
    if (wr && ofs == OFS_TIMER_CTRL && wdata_i[TCTRL_PEND]) pend_d = 1'b0;
    if (tmr_set) pend_d = 1'b1;
  end

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      exit_vld_q <= 1'b0;
      exit_val_q <= '0;
      cycle_q    <= '0;
      cmp_q      <= '0;
      en_q       <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      rvalid_q   <= gnt_o;
      rdata_q    <= rdata_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      exit_vld_q <= exit_vld_d;
      exit_val_q <= exit_val_d;
      cycle_q    <= cycle_d;
      cmp_q      <= cmp_d;
      en_q       <= en_d;
      pend_q     <= pend_d;
    end
  end

  assign rvalid_o       = rvalid_q;
  assign rdata_o        = rdata_q;
  assign tests_passed_o = pass_q;
  assign tests_failed_o = fail_q;
  assign exit_valid_o   = exit_vld_q;
  assign exit_value_o   = exit_val_q;
  assign irq_timer_o    = pend_q & en_q;

endmodule

// File: tb/tb_tb_virt_periph.sv
// Directed bench for tb_virt_periph: bus protocol, stdout FIFO, status pulses, timer.
module tb_tb_virt_periph;
  import tb_virt_periph_pkg::*;

  localparam logic [31:0] BASE  = 32'h2000_0000;
  localparam logic [31:0] MAGIC = 32'd123456789;

  logic        core_clk = 1'b0, core_rst_n = 1'b0;
  logic        req_i = 1'b0, we_i = 1'b0, stdout_ready_i = 1'b0;
  logic [31:0] addr_i = '0, wdata_i = '0;
  logic [3:0]  be_i = '0;
  logic        gnt_o, rvalid_o, sel_o, stdout_valid_o;
  logic        tests_passed_o, tests_failed_o, exit_valid_o, irq_timer_o;
  logic [31:0] rdata_o, exit_value_o;
  logic [7:0]  stdout_char_o;

  int tests = 0, fails = 0;
  logic [31:0] rd;
  logic [7:0]  exp5 [5];

  always #5 core_clk = ~core_clk;

  tb_virt_periph dut (
    .core_clk(core_clk), .core_rst_n(core_rst_n), .req_i(req_i), .gnt_o(gnt_o),
    .addr_i(addr_i), .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .sel_o(sel_o),
    .stdout_valid_o(stdout_valid_o), .stdout_ready_i(stdout_ready_i),
    .stdout_char_o(stdout_char_o), .tests_passed_o(tests_passed_o),
    .tests_failed_o(tests_failed_o), .exit_valid_o(exit_valid_o),
    .exit_value_o(exit_value_o), .irq_timer_o(irq_timer_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_out"}, {gnt_o, rvalid_o, sel_o, stdout_valid_o, tests_passed_o,
                        tests_failed_o, exit_valid_o, irq_timer_o}, 32'h0);
    chk({tag, "_data"}, rdata_o | exit_value_o | {24'h0, stdout_char_o}, 32'h0);
  endtask

  // One OBI access; returns at 1ns after the response edge.
  task automatic bus(input logic w, input logic [7:0] ofs, input logic [31:0] wd,
                     input logic [3:0] be, output logic [31:0] rdat);
    int n = 0;
    req_i = 1'b1; we_i = w; addr_i = BASE | {24'h0, ofs}; wdata_i = wd; be_i = be;
    #1;
    while (gnt_o !== 1'b1 && n < 50) begin @(posedge core_clk); #1; n++; end
    if (gnt_o !== 1'b1) begin
      chk("gnt_timeout", {31'h0, gnt_o}, 32'h1);
      req_i = 1'b0; rdat = 'x;
      return;
    end
    @(posedge core_clk); #1;
    req_i = 1'b0; we_i = 1'b0;
    chk("rvalid", {31'h0, rvalid_o}, 32'h1);
    rdat = rdata_o;
    if (w) chk("wr_rdata", rdata_o, 32'h0);
  endtask

  initial begin
    exp5 = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
    #12 all_zero("in_reset");
    #8 core_rst_n = 1'b1;
    #1 all_zero("post_reset");

    // Ten edges after release the counter holds 10; the read samples it at the grant edge.
    repeat (10) @(posedge core_clk);
    #1 bus(1'b0, OFS_CYCLE, 32'h0, 4'hF, rd);
    chk("cycle_at_10", rd, 32'd10);
    @(posedge core_clk); #1 chk("rdata_idle", rdata_o, 32'h0);

    // 'H' then 'i' on consecutive cycles
    stdout_ready_i = 1'b1;
    bus(1'b1, OFS_STDOUT, 32'h48, 4'hF, rd);
    chk("char_H", {23'h0, stdout_valid_o, stdout_char_o}, {23'h0, 1'b1, 8'h48});
    bus(1'b1, OFS_STDOUT, 32'h69, 4'hF, rd);
    chk("char_i", {23'h0, stdout_valid_o, stdout_char_o}, {23'h0, 1'b1, 8'h69});
    @(posedge core_clk); #1 chk("stdout_drained", {31'h0, stdout_valid_o}, 32'h0);

    // Fill the FIFO with the sink stalled, then a fifth write must wait
    stdout_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) bus(1'b1, OFS_STDOUT, {24'h0, exp5[i]}, 4'h0, rd);
    chk("fifo_head", {23'h0, stdout_valid_o, stdout_char_o}, {23'h0, 1'b1, 8'h41});
    req_i = 1'b1; we_i = 1'b1; addr_i = BASE; wdata_i = {24'h0, exp5[4]};
    #1 chk("stall_gnt", {31'h0, gnt_o}, 32'h0);
    chk("stall_sel", {31'h0, sel_o}, 32'h1);
    @(posedge core_clk); #1 chk("stall_gnt2", {31'h0, gnt_o}, 32'h0);
    @(negedge core_clk); stdout_ready_i = 1'b1;
    #1 chk("unstall_gnt", {31'h0, gnt_o}, 32'h1);
    @(posedge core_clk); #1 req_i = 1'b0; we_i = 1'b0;
    chk("unstall_rvalid", {31'h0, rvalid_o}, 32'h1);
    for (int i = 1; i < 5; i++) begin
      chk($sformatf("fifo_order%0d", i), {23'h0, stdout_valid_o, stdout_char_o},
          {23'h0, 1'b1, exp5[i]});
      @(posedge core_clk); #1;
    end
    chk("fifo_empty", {31'h0, stdout_valid_o}, 32'h0);

    // Test status pulses
    bus(1'b1, OFS_TEST_STATUS, MAGIC, 4'h0, rd);
    chk("pass_pulse", {30'h0, tests_passed_o, tests_failed_o}, 32'h2);
    @(posedge core_clk); #1 chk("pass_end", {31'h0, tests_passed_o}, 32'h0);
    bus(1'b1, OFS_TEST_STATUS, 32'd1, 4'h0, rd);
    chk("fail_pulse", {30'h0, tests_passed_o, tests_failed_o}, 32'h1);
    @(posedge core_clk); #1 chk("fail_end", {31'h0, tests_failed_o}, 32'h0);
    bus(1'b1, OFS_TEST_STATUS, 32'd7, 4'hF, rd);
    chk("other_none", {30'h0, tests_passed_o, tests_failed_o}, 32'h0);
    @(posedge core_clk); #1 chk("other_none2", {30'h0, tests_passed_o, tests_failed_o}, 32'h0);

    // Exit
    bus(1'b1, OFS_EXIT, 32'h2A, 4'h1, rd);
    chk("exit_pulse", {31'h0, exit_valid_o}, 32'h1);
    chk("exit_val", exit_value_o, 32'd42);
    @(posedge core_clk); #1 chk("exit_end", {31'h0, exit_valid_o}, 32'h0);
    chk("exit_held", exit_value_o, 32'd42);

    // Timer: CYCLE=40 at edge G, CMP at G+1, EN at G+2; CYCLE reaches 50 after G+10
    bus(1'b1, OFS_CYCLE, 32'd40, 4'hF, rd);
    bus(1'b1, OFS_TIMER_CMP, 32'd50, 4'hF, rd);
    bus(1'b1, OFS_TIMER_CTRL, 32'd1, 4'hF, rd);
    repeat (8) @(posedge core_clk);
    #1 chk("irq_before", {31'h0, irq_timer_o}, 32'h0);
    @(posedge core_clk); #1 chk("irq_rise", {31'h0, irq_timer_o}, 32'h1);
    bus(1'b0, OFS_TIMER_CTRL, 32'h0, 4'hF, rd);
    chk("ctrl_pending", rd, 32'h3);
    bus(1'b1, OFS_TIMER_CTRL, 32'd3, 4'hF, rd);
    chk("irq_cleared", {31'h0, irq_timer_o}, 32'h0);
    bus(1'b0, OFS_TIMER_CTRL, 32'h0, 4'hF, rd);
    chk("ctrl_after_clr", rd, 32'h1);

    // Byte enables on TIMER_CMP: lanes 0 and 2 only, over 0x32
    bus(1'b1, OFS_TIMER_CMP, 32'hAABB_CCDD, 4'b0101, rd);
    bus(1'b0, OFS_TIMER_CMP, 32'h0, 4'hF, rd);
    chk("cmp_be", rd, 32'h00BB_00DD);

    // Unmapped offset and out-of-window address
    bus(1'b0, 8'h40, 32'h0, 4'hF, rd);
    chk("unmapped", rd, 32'hDEAD_BEEF);
    req_i = 1'b1; addr_i = 32'h3000_0010;
    #1 chk("outside", {30'h0, sel_o, gnt_o}, 32'h0);
    req_i = 1'b0;

    // Reset while a pulse, an rvalid and FIFO contents are live
    stdout_ready_i = 1'b0;
    bus(1'b1, OFS_STDOUT, 32'h5A, 4'hF, rd);
    bus(1'b1, OFS_TEST_STATUS, MAGIC, 4'hF, rd);
    chk("pre_rst_live", {29'h0, rvalid_o, tests_passed_o, stdout_valid_o}, 32'h7);
    core_rst_n = 1'b0;
    #1 chk("mid_rst_clear", {29'h0, rvalid_o, tests_passed_o, stdout_valid_o}, 32'h0);
    @(negedge core_clk); core_rst_n = 1'b1;
    @(posedge core_clk); #1 all_zero("after_mid_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
